// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_reader
//  Purpose  : Read-side master for a non-FWFT FIFO primitive (FIFO18E1 style).
//             Issues fifo_rd_en under a credit rule, absorbs the fixed read
//             latency in a small circular skid buffer and presents the data
//             as a valid/ready stream sustaining one word per cycle.
//  Ports    :
//    rd_clk      in   1      read-domain clock, rising edge
//    rst         in   1      asynchronous reset, active-high
//    fifo_dout   in   WIDTH  FIFO read data, valid RD_LATENCY cycles after rd_en
//    fifo_empty  in   1      FIFO empty flag
//    fifo_rderr  in   1      FIFO read-error flag
//    fifo_rd_en  out  1      FIFO read enable
//    m_data      out  WIDTH  stream data (head of skid buffer)
//    m_valid     out  1      stream data valid
//    m_ready     in   1      consumer accepts m_data this cycle
//    words_read  out  16     count of accepted stream words, wraps
//    buf_level   out  3      skid buffer occupancy, 0..BUF_DEPTH
//    rd_err      out  1      sticky FIFO read-error flag, cleared by rst
//  Parameters: WIDTH (9/18/36), RD_LATENCY (1 or 2),
//              BUF_DEPTH (>= RD_LATENCY+1 and <= 7 so it fits buf_level)
//  Revision : 1.0  initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int WIDTH      = 9,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_rderr,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      words_read,
    output logic [2:0]       buf_level,
    output logic             rd_err
);

    localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_SUM_W = 8;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(BUF_DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [WIDTH-1:0]      mem_q [BUF_DEPTH];
    logic [c_PTR_W-1:0]    head_q, head_d;
    logic [c_PTR_W-1:0]    tail_q, tail_d;
    logic [2:0]            level_q, level_d;
    logic [WIDTH-1:0]      last_q, last_d;
    logic [15:0]           words_q, words_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic                  capture;
    logic [c_SUM_W-1:0]    inflight_cnt;
    logic [c_SUM_W-1:0]    committed;

    // A read issued in cycle t shifts to the top bit after RD_LATENCY edges,
    // which is exactly the cycle in which fifo_dout carries its data.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign inflight_d = fifo_rd_en;
        end else begin : g_latn
            assign inflight_d = {inflight_q[RD_LATENCY-2:0], fifo_rd_en};
        end
    endgenerate

    assign capture = inflight_q[RD_LATENCY-1];
    assign m_valid = (level_q != 3'd0);
    assign pop     = m_valid & m_ready;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + c_SUM_W'(inflight_q[i]);
        end
    end

    // Credit: every slot already promised (in flight or held) must leave room
    // for one more word. Crediting this cycle's pop keeps one word per cycle
    // flowing when the consumer is always ready. level_q >= pop, so no underflow.
    assign committed  = inflight_cnt + c_SUM_W'(level_q) - c_SUM_W'(pop);
    assign fifo_rd_en = ~fifo_empty & ~rst & (committed < c_SUM_W'(BUF_DEPTH));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        last_d  = last_q;
        words_d = words_q;
        err_d   = err_q | fifo_rderr;

        // Explicit wrap so non-power-of-two depths work.
        if (capture) begin
            tail_d = (tail_q == c_LAST_PTR) ? '0 : tail_q + c_PTR_W'(1);
        end
        if (pop) begin
            head_d  = (head_q == c_LAST_PTR) ? '0 : head_q + c_PTR_W'(1);
            last_d  = mem_q[head_q];
            words_d = words_q + 16'd1;
        end

        case ({capture, pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            last_q     <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            last_q     <= last_d;
            words_q    <= words_d;
            err_q      <= err_d;
            if (capture) begin
                mem_q[tail_q] <= fifo_dout;
            end
        end
    end

    // When the buffer drains, m_data keeps showing the last word delivered
    // rather than whatever stale entry the head pointer now addresses.
    assign m_data     = m_valid ? mem_q[head_q] : last_q;
    assign words_read = words_q;
    assign buf_level  = level_q;
    assign rd_err     = err_q;

    // The credit rule keeps a free slot for every in-flight read.
    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rst)
        capture |-> (level_q < 3'(BUF_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_stream_reader
//  Purpose  : Self-checking bench for fifo_stream_reader. Two instances:
//             u_dut0 with RD_LATENCY=1 and u_dut1 with RD_LATENCY=2, each fed
//             by a behavioural non-FWFT FIFO model. Expected words are queued
//             when written into the FIFO and compared as the stream delivers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b1;
    logic       hold_ne = 1'b1;

    logic       empty0 = 1'b0, rderr0 = 1'b0, mready0 = 1'b1;
    logic       rd_en0, mvalid0, rd_err0;
    logic [8:0] dout0 = '0, mdata0;
    logic [15:0] words0;
    logic [2:0] lvl0;

    logic       empty1 = 1'b0, rderr1 = 1'b0, mready1 = 1'b0;
    logic       rd_en1, mvalid1, rd_err1;
    logic [8:0] dout1 = '0, stg1 = '0, mdata1;
    logic [15:0] words1;
    logic [2:0] lvl1;

    fifo_stream_reader #(.WIDTH(9), .RD_LATENCY(1)) u_dut0 (
        .rd_clk(clk), .rst(rst), .fifo_dout(dout0), .fifo_empty(empty0),
        .fifo_rderr(rderr0), .fifo_rd_en(rd_en0), .m_data(mdata0),
        .m_valid(mvalid0), .m_ready(mready0), .words_read(words0),
        .buf_level(lvl0), .rd_err(rd_err0)
    );

    fifo_stream_reader #(.WIDTH(9), .RD_LATENCY(2)) u_dut1 (
        .rd_clk(clk), .rst(rst), .fifo_dout(dout1), .fifo_empty(empty1),
        .fifo_rderr(rderr1), .fifo_rd_en(rd_en1), .m_data(mdata1),
        .m_valid(mvalid1), .m_ready(mready1), .words_read(words1),
        .buf_level(lvl1), .rd_err(rd_err1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [8:0] fq0[$], fq1[$], ex0[$], ex1[$];

    // FIFO models: data appears RD_LATENCY cycles after the rd_en cycle.
    always @(posedge clk) begin
        if (rst) begin
            fq0.delete();
            empty0 <= ~hold_ne;
        end else begin
            if (rd_en0) begin
                check("rd_on_empty0", 32'(empty0), 32'd0);
                if (fq0.size() > 0) dout0 <= fq0.pop_front();
            end
            empty0 <= (fq0.size() == 0);
        end
    end

    always @(posedge clk) begin
        dout1 <= stg1;
        if (rst) begin
            fq1.delete();
            stg1   <= '0;
            empty1 <= ~hold_ne;
        end else begin
            if (rd_en1) begin
                check("rd_on_empty1", 32'(empty1), 32'd0);
                if (fq1.size() > 0) stg1 <= fq1.pop_front();
            end
            empty1 <= (fq1.size() == 0);
        end
    end

    // Stream monitors: scoreboard, handshake stability, run length, rd_en count.
    int run0 = 0, maxrun0 = 0, rdcnt0 = 0;
    int run1 = 0, maxrun1 = 0, rdcnt1 = 0;
    logic pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
    logic [8:0] pd0 = '0, pd1 = '0;

    always @(negedge clk) begin
        if (rd_en0) rdcnt0++;
        if (mvalid0) begin run0++; if (run0 > maxrun0) maxrun0 = run0; end
        else run0 = 0;
        if (rst) pv0 = 1'b0;
        else begin
            if (pv0 && !pr0) begin
                check("hold_valid0", 32'(mvalid0), 32'd1);
                check("hold_data0", 32'(mdata0), 32'(pd0));
            end
            if (mvalid0 && mready0) begin
                if (ex0.size() == 0) check("sb_underflow0", 32'(ex0.size()), 32'd1);
                else check("data0", 32'(mdata0), 32'(ex0.pop_front()));
            end
            pv0 = mvalid0; pr0 = mready0; pd0 = mdata0;
        end
    end

    always @(negedge clk) begin
        if (rd_en1) rdcnt1++;
        if (mvalid1) begin run1++; if (run1 > maxrun1) maxrun1 = run1; end
        else run1 = 0;
        if (rst) pv1 = 1'b0;
        else begin
            if (pv1 && !pr1) begin
                check("hold_valid1", 32'(mvalid1), 32'd1);
                check("hold_data1", 32'(mdata1), 32'(pd1));
            end
            if (mvalid1 && mready1) begin
                if (ex1.size() == 0) check("sb_underflow1", 32'(ex1.size()), 32'd1);
                else check("data1", 32'(mdata1), 32'(ex1.pop_front()));
            end
            pv1 = mvalid1; pr1 = mready1; pd1 = mdata1;
        end
    end

    task automatic push(input int k, input logic [8:0] w);
        if (k == 0) begin fq0.push_back(w); ex0.push_back(w); empty0 = 1'b0; end
        else        begin fq1.push_back(w); ex1.push_back(w); empty1 = 1'b0; end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        ex0.delete(); ex1.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (ex0.size() != 0 || ex1.size() != 0); i++) step();
        repeat (3) step();
        check("drain0", 32'(ex0.size()), 32'd0);
        check("drain1", 32'(ex1.size()), 32'd0);
    endtask

    int base;

    initial begin
        // 1: reset held with a non-empty FIFO
        repeat (3) begin
            @(negedge clk);
            check("rst_rd_en0", 32'(rd_en0), 32'd0);
            check("rst_rd_en1", 32'(rd_en1), 32'd0);
            check("rst_valid0", 32'(mvalid0), 32'd0);
            check("rst_valid1", 32'(mvalid1), 32'd0);
        end
        check("rst_words0", 32'(words0), 32'd0);
        check("rst_err0", 32'(rd_err0), 32'd0);
        check("rst_data0", 32'(mdata0), 32'd0);
        check("rst_level1", 32'(lvl1), 32'd0);
        step();
        hold_ne = 1'b0; empty0 = 1'b1; empty1 = 1'b1; rst = 1'b0;

        // 2: single word through the latency-1 reader
        step();
        push(0, 9'h1A5);
        @(negedge clk);
        check("t2_rd_en_t", 32'(rd_en0), 32'd1);
        check("t2_valid_t", 32'(mvalid0), 32'd0);
        @(negedge clk);
        check("t2_rd_en_t1", 32'(rd_en0), 32'd0);
        check("t2_valid_t1", 32'(mvalid0), 32'd0);
        @(negedge clk);
        check("t2_valid_t2", 32'(mvalid0), 32'd1);
        check("t2_data_t2", 32'(mdata0), 32'h1A5);
        @(negedge clk);
        check("t2_valid_t3", 32'(mvalid0), 32'd0);
        check("t2_words", 32'(words0), 32'd1);
        check("t2_rd_en_t3", 32'(rd_en0), 32'd0);
        check("t2_data_held", 32'(mdata0), 32'h1A5);

        // 3: latency-2 reader under backpressure, then release
        step();
        base = rdcnt1;
        for (int i = 0; i < 10; i++) push(1, 9'(i));
        repeat (8) step();
        check("t3_rd_pulses", 32'(rdcnt1 - base), 32'd3);
        check("t3_level", 32'(lvl1), 32'd3);
        check("t3_data", 32'(mdata1), 32'd0);
        check("t3_valid", 32'(mvalid1), 32'd1);
        run1 = 0; maxrun1 = 0;
        mready1 = 1'b1;
        drain(100);
        check("t3_run", 32'(maxrun1), 32'd10);
        check("t3_words", 32'(words1), 32'd10);

        // 4: 256 words back-to-back on both readers, then toggling ready
        do_reset();
        mready0 = 1'b1; mready1 = 1'b1;
        run0 = 0; maxrun0 = 0; run1 = 0; maxrun1 = 0;
        for (int i = 0; i < 256; i++) begin
            push(0, 9'(i * 37 + 5));
            push(1, 9'(i * 37 + 5));
        end
        drain(600);
        check("t4_run0", 32'(maxrun0), 32'd256);
        check("t4_run1", 32'(maxrun1), 32'd256);
        check("t4_words0", 32'(words0), 32'd256);
        check("t4_words1", 32'(words1), 32'd256);
        for (int i = 0; i < 100; i++) begin
            push(0, 9'(i * 11 + 300));
            push(1, 9'(i * 13 + 7));
        end
        for (int i = 0; i < 1000 && (ex0.size() != 0 || ex1.size() != 0); i++) begin
            mready0 = ~mready0; mready1 = ~mready1;
            step();
        end
        mready0 = 1'b1; mready1 = 1'b1;
        drain(10);
        check("t4_words0_tog", 32'(words0), 32'd356);
        check("t4_words1_tog", 32'(words1), 32'd356);

        // 5: sticky read-error flag, stream keeps running
        rderr0 = 1'b1;
        step();
        rderr0 = 1'b0;
        @(negedge clk);
        check("t5_err_set", 32'(rd_err0), 32'd1);
        step();
        for (int i = 0; i < 5; i++) push(0, 9'(i + 100));
        drain(50);
        check("t5_err_sticky", 32'(rd_err0), 32'd1);
        check("t5_err_other", 32'(rd_err1), 32'd0);
        check("t5_words0", 32'(words0), 32'd361);

        // 6: reset with reads in flight and words buffered
        do_reset();
        check("t6_err_cleared", 32'(rd_err0), 32'd0);
        mready1 = 1'b0;
        step();
        for (int i = 0; i < 10; i++) push(1, 9'(i + 50));
        repeat (3) step();
        check("t6_level_pre", 32'(lvl1), 32'd1);
        rst = 1'b1;
        ex0.delete(); ex1.delete();
        #1;
        check("t6_valid_now", 32'(mvalid1), 32'd0);
        check("t6_level_now", 32'(lvl1), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        mready1 = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("t6_no_stale", 32'(mvalid1), 32'd0);
        end
        check("t6_words", 32'(words1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
